// File: rtl/core_pkg.sv
// Shared load/store encodings: access-size codes, big-endian byte-lane masks
// and the aligned-store record produced before the store-data registers.
package core_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    // Bit 0 of a mask is byte lane [31:24]; lane 3 is [7:0].
    localparam logic [3:0] MASK_NONE    = 4'b0000;
    localparam logic [3:0] MASK_BYTE0   = 4'b0001;
    localparam logic [3:0] MASK_HALF_HI = 4'b0011;
    localparam logic [3:0] MASK_HALF_LO = 4'b1100;
    localparam logic [3:0] MASK_WORD    = 4'b1111;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
        logic        misalign;
    } st_align_t;

endpackage

// File: rtl/execute_store_data_align.sv
// Combinational store alignment: places right-justified register data into
// its big-endian byte lanes and flags misaligned or reserved-size accesses.
module execute_store_data_align
    import core_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_data,
    output st_align_t   o_res
);

    logic [4:0] w_byte_shift;

    // Byte at address a lands (3-a) lanes above bit 0.
    assign w_byte_shift = {~i_addr, 3'b000};

    always_comb begin
        o_res = '0;
        case (i_size)
            SIZE_BYTE: begin
                o_res.mask = MASK_BYTE0 << i_addr;
                o_res.data = {24'h000000, i_data[7:0]} << w_byte_shift;
            end
            SIZE_HALF: begin
                if (i_addr[0]) begin
                    o_res.misalign = 1'b1;
                end else if (i_addr[1]) begin
                    o_res.mask = MASK_HALF_LO;
                    o_res.data = {16'h0000, i_data[15:0]};
                end else begin
                    o_res.mask = MASK_HALF_HI;
                    o_res.data = {i_data[15:0], 16'h0000};
                end
            end
            SIZE_WORD: begin
                if (i_addr != 2'd0) begin
                    o_res.misalign = 1'b1;
                end else begin
                    o_res.mask = MASK_WORD;
                    o_res.data = i_data;
                end
            end
            default: o_res.misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/execute_store_data_pipe.sv
// Registered store-data stage between execute and the load/store unit:
// output register plus one skid entry, with registered backpressure.
module execute_store_data_pipe
    import core_pkg::*;
#(
    parameter int P_TAG_W = 4
) (
    input  logic               iCLOCK,
    input  logic               iRESET,
    input  logic               iFLUSH,
    input  logic               iPREV_VALID,
    output logic               oPREV_BUSY,
    input  logic [1:0]         iPREV_SIZE,
    input  logic [1:0]         iPREV_ADDR,
    input  logic [31:0]        iPREV_DATA,
    input  logic [P_TAG_W-1:0] iPREV_TAG,
    output logic               oNEXT_VALID,
    input  logic               iNEXT_BUSY,
    output logic [3:0]         oNEXT_MASK,
    output logic [31:0]        oNEXT_DATA,
    output logic [P_TAG_W-1:0] oNEXT_TAG,
    output logic               oNEXT_MISALIGN
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    st_align_t           r_out;
    st_align_t           r_skid;
    logic [P_TAG_W-1:0]  r_out_tag;
    logic [P_TAG_W-1:0]  r_skid_tag;

    st_align_t           w_new;
    logic                w_accept;
    logic                w_consume;

    execute_store_data_align u_align (
        .i_size (iPREV_SIZE),
        .i_addr (iPREV_ADDR),
        .i_data (iPREV_DATA),
        .o_res  (w_new)
    );

    // Busy is exactly "skid occupied", i.e. the FULL state register.
    assign oPREV_BUSY  = (r_state == ST_FULL);
    assign oNEXT_VALID = (r_state != ST_EMPTY);
    assign w_accept    = iPREV_VALID && !oPREV_BUSY;
    assign w_consume   = oNEXT_VALID && !iNEXT_BUSY;

    assign oNEXT_MASK     = r_out.mask;
    assign oNEXT_DATA     = r_out.data;
    assign oNEXT_MISALIGN = r_out.misalign;
    assign oNEXT_TAG      = r_out_tag;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_state    <= ST_EMPTY;
            r_out      <= '0;
            r_skid     <= '0;
            r_out_tag  <= '0;
            r_skid_tag <= '0;
        end else if (iFLUSH) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_out     <= w_new;
                        r_out_tag <= iPREV_TAG;
                        r_state   <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        r_out     <= w_new;
                        r_out_tag <= iPREV_TAG;
                    end else if (w_accept) begin
                        r_skid     <= w_new;
                        r_skid_tag <= iPREV_TAG;
                        r_state    <= ST_FULL;
                    end else if (w_consume) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // No accept is possible here: busy is asserted.
                    if (w_consume) begin
                        r_out     <= r_skid;
                        r_out_tag <= r_skid_tag;
                        r_state   <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_store_data_pipe.sv
// Self-checking bench: directed scenarios then random traffic, compared
// against a queue-based reference of the store-data stage.
module tb_execute_store_data_pipe;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        logic [3:0]  tag;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        prev_valid;
    logic        prev_busy;
    logic [1:0]  prev_size;
    logic [1:0]  prev_addr;
    logic [31:0] prev_data;
    logic [3:0]  prev_tag;
    logic        next_valid;
    logic        next_busy;
    logic [3:0]  next_mask;
    logic [31:0] next_data;
    logic [3:0]  next_tag;
    logic        next_mis;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    execute_store_data_pipe #(.P_TAG_W(4)) dut (
        .iCLOCK        (clk),
        .iRESET        (rst),
        .iFLUSH        (flush),
        .iPREV_VALID   (prev_valid),
        .oPREV_BUSY    (prev_busy),
        .iPREV_SIZE    (prev_size),
        .iPREV_ADDR    (prev_addr),
        .iPREV_DATA    (prev_data),
        .iPREV_TAG     (prev_tag),
        .oNEXT_VALID   (next_valid),
        .iNEXT_BUSY    (next_busy),
        .oNEXT_MASK    (next_mask),
        .oNEXT_DATA    (next_data),
        .oNEXT_TAG     (next_tag),
        .oNEXT_MISALIGN(next_mis)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference alignment from the access width: n bytes starting at addr,
    // byte 0 being the most significant lane.
    function automatic exp_t align_ref(input int size, input int addr, input logic [31:0] d,
                                       input logic [3:0] tag);
        exp_t e;
        int   nb;
        logic [63:0] val;
        e.tag = tag;
        e.mask = 4'h0;
        e.data = 32'h0;
        e.mis = 1'b0;
        if (size == 3) begin
            e.mis = 1'b1;
        end else begin
            nb = 1 << size;
            if ((addr % nb) != 0) begin
                e.mis = 1'b1;
            end else begin
                e.mask = 4'(((1 << nb) - 1) << addr);
                val = 64'(d) & ((64'd1 << (8 * nb)) - 64'd1);
                e.data = 32'(val << (8 * (4 - addr - nb)));
            end
        end
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 32'(next_valid), 32'(q.size() > 0));
        chk({tag, ".busy"},  32'(prev_busy),  32'(q.size() == 2));
        if (q.size() > 0) begin
            chk({tag, ".mask"}, 32'(next_mask), 32'(q[0].mask));
            chk({tag, ".data"}, next_data, q[0].data);
            chk({tag, ".tag"},  32'(next_tag), 32'(q[0].tag));
            chk({tag, ".mis"},  32'(next_mis), 32'(q[0].mis));
        end
    endtask

    // Drive one cycle of inputs (called just after a falling edge), advance
    // the reference across the rising edge, then check at the next falling edge.
    task automatic cycle(input string tag, input logic v, input logic [1:0] sz, input logic [1:0] ad,
                         input logic [31:0] d, input logic [3:0] tg, input logic nb, input logic fl);
        logic was_valid;
        logic was_busy;
        prev_valid = v;
        prev_size  = sz;
        prev_addr  = ad;
        prev_data  = d;
        prev_tag   = tg;
        next_busy  = nb;
        flush      = fl;
        was_valid  = (q.size() > 0);
        was_busy   = (q.size() == 2);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (was_valid && !nb) void'(q.pop_front());
            if (v && !was_busy) q.push_back(align_ref(int'(sz), int'(ad), d, tg));
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        prev_valid = 1'b0;
        prev_size = 2'd0;
        prev_addr = 2'd0;
        prev_data = 32'h0;
        prev_tag = 4'h0;
        next_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.valid", 32'(next_valid), 32'd0);
        chk("rst.busy",  32'(prev_busy),  32'd0);
        chk("rst.mask",  32'(next_mask),  32'd0);
        chk("rst.data",  next_data,       32'd0);
        chk("rst.tag",   32'(next_tag),   32'd0);
        chk("rst.mis",   32'(next_mis),   32'd0);
        rst = 1'b0;

        // Byte lanes, no stall.
        for (int a = 0; a < 4; a++)
            cycle("byte", 1'b1, 2'd0, 2'(a), 32'h000000A5, 4'(a), 1'b0, 1'b0);
        chk("byte3.data", next_data, 32'h000000A5);
        // Halves and word.
        cycle("half0", 1'b1, 2'd1, 2'd0, 32'h0000BEEF, 4'h4, 1'b0, 1'b0);
        chk("half0.data", next_data, 32'hBEEF0000);
        cycle("half2", 1'b1, 2'd1, 2'd2, 32'h0000BEEF, 4'h5, 1'b0, 1'b0);
        chk("half2.mask", 32'(next_mask), 32'hC);
        cycle("word", 1'b1, 2'd2, 2'd0, 32'h12345678, 4'h6, 1'b0, 1'b0);
        chk("word.data", next_data, 32'h12345678);
        // Misaligned and reserved.
        cycle("mis_h1", 1'b1, 2'd1, 2'd1, 32'hFFFFFFFF, 4'h7, 1'b0, 1'b0);
        cycle("mis_w2", 1'b1, 2'd2, 2'd2, 32'hFFFFFFFF, 4'h8, 1'b0, 1'b0);
        cycle("mis_rs", 1'b1, 2'd3, 2'd0, 32'hFFFFFFFF, 4'h9, 1'b0, 1'b0);
        chk("mis_rs.flag", 32'(next_mis), 32'd1);
        cycle("drain", 1'b0, 2'd0, 2'd0, 32'h0, 4'h0, 1'b0, 1'b0);

        // Stall: tags 1,2,3 under busy; tag3 held off until skid drains.
        cycle("stall1", 1'b1, 2'd2, 2'd0, 32'h11111111, 4'h1, 1'b1, 1'b0);
        cycle("stall2", 1'b1, 2'd2, 2'd0, 32'h22222222, 4'h2, 1'b1, 1'b0);
        cycle("stall3", 1'b1, 2'd2, 2'd0, 32'h33333333, 4'h3, 1'b1, 1'b0);
        chk("stall.busy", 32'(prev_busy), 32'd1);
        for (int i = 0; i < 5; i++)
            cycle("release", (q.size() == 2) ? 1'b1 : 1'b0, 2'd2, 2'd0, 32'h33333333, 4'h3, 1'b0, 1'b0);
        chk("release.empty", 32'(next_valid), 32'd0);

        // Flush with FULL occupancy and a request in the flush cycle.
        cycle("fill1", 1'b1, 2'd0, 2'd1, 32'h5A, 4'hA, 1'b1, 1'b0);
        cycle("fill2", 1'b1, 2'd0, 2'd2, 32'h5B, 4'hB, 1'b1, 1'b0);
        cycle("flush", 1'b1, 2'd0, 2'd3, 32'h5C, 4'hC, 1'b1, 1'b1);
        cycle("postfl", 1'b0, 2'd0, 2'd0, 32'h0, 4'h0, 1'b0, 1'b0);

        // Random traffic with an asynchronous reset in the middle.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                cycle("prerst", 1'b1, 2'd2, 2'd0, 32'hCAFEF00D, 4'hE, 1'b1, 1'b0);
                @(posedge clk);
                #3 rst = 1'b1;
                #1;
                chk("arst.valid", 32'(next_valid), 32'd0);
                chk("arst.busy",  32'(prev_busy),  32'd0);
                chk("arst.mask",  32'(next_mask),  32'd0);
                chk("arst.data",  next_data,       32'd0);
                q.delete();
                prev_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                cycle("postrst", 1'b1, 2'd0, 2'd2, 32'h00000077, 4'hD, 1'b0, 1'b0);
                chk("postrst.data", next_data, 32'h00007700);
            end
            cycle("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom), $urandom,
                  4'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
